// File: rtl/cacheline_adaptor.sv
// Bridges one 256-bit L2 cacheline transfer to a 4-beat 64-bit physical-memory burst (fill and writeback).
// Outputs are registered and updated together with the state, so no cache input reaches a memory output combinationally.
module cacheline_adaptor #(
    parameter int s_offset  = 5,
    parameter int s_line    = 256,
    parameter int s_burst   = 64,
    parameter int num_beats = s_line / s_burst
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [s_line-1:0]   line_i,
    output logic [s_line-1:0]   line_o,
    input  logic [31:0]         address_i,
    input  logic                read_i,
    input  logic                write_i,
    output logic                resp_o,
    input  logic [s_burst-1:0]  burst_i,
    output logic [s_burst-1:0]  burst_o,
    output logic [31:0]         address_o,
    output logic                read_o,
    output logic                write_o,
    input  logic                resp_i,
    output logic [1:0]          dbg_state
);

    localparam int beat_w = $clog2(num_beats);
    localparam logic [beat_w-1:0] last_beat = beat_w'(num_beats - 1);

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

    state_t              state;
    logic [beat_w-1:0]   beat;
    logic [beat_w-1:0]   beat_nxt;
    logic [s_line-1:0]   line_buf;
    logic [31:0]         addr_q;
    logic [31:0]         line_addr;
    logic                unused_offset_bits;

    assign beat_nxt           = beat + 1'b1;
    assign line_addr          = {address_i[31:s_offset], {s_offset{1'b0}}};
    assign unused_offset_bits = ^address_i[s_offset-1:0];
    assign line_o             = line_buf;
    assign dbg_state          = state;

    // Write has priority over read in IDLE: a dirty victim must reach memory before the fill.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            beat      <= '0;
            line_buf  <= '0;
            addr_q    <= '0;
            resp_o    <= 1'b0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            burst_o   <= '0;
            address_o <= '0;
        end else begin
            resp_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (write_i) begin
                        addr_q    <= line_addr;
                        address_o <= line_addr;
                        line_buf  <= line_i;
                        beat      <= '0;
                        write_o   <= 1'b1;
                        burst_o   <= line_i[s_burst-1:0];
                        state     <= WR_BURST;
                    end else if (read_i) begin
                        addr_q    <= line_addr;
                        address_o <= line_addr;
                        beat      <= '0;
                        read_o    <= 1'b1;
                        state     <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (resp_i) begin
                        line_buf[int'(beat)*s_burst +: s_burst] <= burst_i;
                        beat <= beat_nxt;
                        if (beat == last_beat) begin
                            read_o    <= 1'b0;
                            address_o <= '0;
                            resp_o    <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                WR_BURST: begin
                    if (resp_i) begin
                        beat <= beat_nxt;
                        if (beat == last_beat) begin
                            write_o   <= 1'b0;
                            address_o <= '0;
                            burst_o   <= '0;
                            resp_o    <= 1'b1;
                            state     <= DONE;
                        end else begin
                            burst_o <= line_buf[int'(beat_nxt)*s_burst +: s_burst];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
